// File: rtl/if_fetch_stage_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DROP} fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

  // Sequential successor address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// One-entry {pc, inst} buffer that parks a returned fetch while IF/ID is stalled.
module if_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        full
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= 32'h0;
      inst <= 32'h0;
      full <= 1'b0;
    end else if (clear) begin
      pc   <= 32'h0;
      inst <= 32'h0;
      full <= 1'b0;
    end else if (load) begin
      pc   <= load_pc;
      inst <= load_inst;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding IM request FSM, IF/ID register,
// hazard stalls and branch/jump redirects with wrong-path squashing.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IF_stage_PCWrite_i,
  input  logic         IF_stage_IFpip_Write_i,
  input  logic         IF_stage_branch_taken_i,
  input  logic         IF_stage_jump_i,
  input  logic [31:0]  IF_stage_branch_target_i,
  output logic         IM_req_o,
  output logic [31:0]  IM_addr_o,
  input  logic         IM_rvalid_i,
  input  logic [31:0]  IM_rdata_i,
  output logic [31:0]  IF_stage_pc_o,
  output logic [31:0]  IF_stage_pc_add4_o,
  output logic [31:0]  IF_stage_Inst_o,
  output logic         IF_stage_valid_o,
  output fetch_state_t fsm_state
);

  // IM handshake: IM_req_o is a one-cycle pulse with IM_addr_o valid alongside it; the
  // memory answers with exactly one IM_rvalid_i pulse (rdata valid with it) at least one
  // cycle later, and no new request is issued until that response has been seen.

  fetch_state_t state;
  logic [31:0]  pc;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         buf_load;
  logic         buf_clear;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_inst;
  logic         buf_full;

  assign redirect    = IF_stage_branch_taken_i | IF_stage_jump_i;
  assign redirect_pc = align_pc(IF_stage_branch_target_i);
  assign IM_addr_o   = pc;
  assign fsm_state   = state;

  always_comb begin
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (redirect) begin
      buf_clear = 1'b1;
    end else if (state == WAIT && IM_rvalid_i && !IF_stage_IFpip_Write_i) begin
      buf_load = 1'b1;
    end else if (state == HOLD && IF_stage_IFpip_Write_i) begin
      buf_clear = 1'b1;
    end
  end

  if_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (pc),
    .load_inst (IM_rdata_i),
    .pc        (buf_pc),
    .inst      (buf_inst),
    .full      (buf_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      pc                 <= RESET_PC;
      IM_req_o           <= 1'b0;
      IF_stage_pc_o      <= 32'h0;
      IF_stage_pc_add4_o <= 32'h0;
      IF_stage_Inst_o    <= NOP_INST;
      IF_stage_valid_o   <= 1'b0;
    end else begin
      IM_req_o <= 1'b0;
      if (redirect) begin
        // A request still in flight belongs to the old path and must be drained in DROP.
        pc                 <= redirect_pc;
        IF_stage_pc_o      <= 32'h0;
        IF_stage_pc_add4_o <= 32'h0;
        IF_stage_Inst_o    <= NOP_INST;
        IF_stage_valid_o   <= 1'b0;
        unique case (state)
          IDLE, HOLD: begin
            state    <= ISSUE;
            IM_req_o <= 1'b1;
          end
          ISSUE: state <= DROP;
          WAIT, DROP: begin
            if (IM_rvalid_i) begin
              state    <= ISSUE;
              IM_req_o <= 1'b1;
            end else begin
              state <= DROP;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        unique case (state)
          IDLE: begin
            state    <= ISSUE;
            IM_req_o <= 1'b1;
          end
          ISSUE: state <= WAIT;
          WAIT: begin
            if (IM_rvalid_i) begin
              if (IF_stage_IFpip_Write_i) begin
                IF_stage_pc_o      <= pc;
                IF_stage_pc_add4_o <= pc_inc(pc);
                IF_stage_Inst_o    <= IM_rdata_i;
                IF_stage_valid_o   <= 1'b1;
                if (IF_stage_PCWrite_i) pc <= pc_inc(pc);
                state    <= ISSUE;
                IM_req_o <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (IF_stage_IFpip_Write_i && buf_full) begin
              IF_stage_pc_o      <= buf_pc;
              IF_stage_pc_add4_o <= pc_inc(buf_pc);
              IF_stage_Inst_o    <= buf_inst;
              IF_stage_valid_o   <= 1'b1;
              if (IF_stage_PCWrite_i) pc <= pc_inc(pc);
              state    <= ISSUE;
              IM_req_o <= 1'b1;
            end
          end
          DROP: begin
            if (IM_rvalid_i) begin
              state    <= ISSUE;
              IM_req_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: latency-randomised instruction memory, random stalls and
// redirects, checked every cycle against a transaction-level fetch model.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         pcwrite, ifpip, branch, jump;
  logic [31:0]  target;
  logic         req;
  logic [31:0]  addr;
  logic         rvalid;
  logic [31:0]  rdata;
  logic [31:0]  pc_o, add4_o, inst_o;
  logic         valid_o;
  fetch_state_t fsm_state;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .IF_stage_PCWrite_i       (pcwrite),
    .IF_stage_IFpip_Write_i   (ifpip),
    .IF_stage_branch_taken_i  (branch),
    .IF_stage_jump_i          (jump),
    .IF_stage_branch_target_i (target),
    .IM_req_o                 (req),
    .IM_addr_o                (addr),
    .IM_rvalid_i              (rvalid),
    .IM_rdata_i               (rdata),
    .IF_stage_pc_o            (pc_o),
    .IF_stage_pc_add4_o       (add4_o),
    .IF_stage_Inst_o          (inst_o),
    .IF_stage_valid_o         (valid_o),
    .fsm_state                (fsm_state)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  // ---------------- driver and instruction memory ----------------
  int          lat_min = 1, lat_max = 1;
  int          p_pcw = 100, p_ifpip = 100, p_redir = 0;
  bit          redir_en = 0;
  bit          force_redir = 0, force_br = 0;
  logic [31:0] force_tgt = 32'h0;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit          captured = 0;

  task automatic drive_cycle(input bit rst_v);
    bit released;
    @(posedge clk);
    #1;
    released = (rst == 1'b0) && rst_v;
    rst      = rst_v;
    rvalid   = 1'b0;
    captured = 0;
    if (released && mem_busy) begin
      rvalid   = 1'b1;
      rdata    = 32'hDEAD_BEEF;
      mem_busy = 0;
    end else if (rst_v && mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rvalid   = 1'b1;
        rdata    = inst_of(mem_addr);
        mem_busy = 0;
      end
    end
    if (rst_v && req) begin
      mem_busy = 1;
      mem_cnt  = $urandom_range(lat_max, lat_min);
      mem_addr = addr;
      captured = 1;
    end
    pcwrite = ($urandom_range(99, 0) < p_pcw);
    ifpip   = ($urandom_range(99, 0) < p_ifpip);
    branch  = 1'b0;
    jump    = 1'b0;
    if (force_redir) begin
      branch      = force_br;
      jump        = !force_br;
      target      = force_tgt;
      force_redir = 0;
    end else if (redir_en && rst_v && !released && $urandom_range(99, 0) < p_redir) begin
      if ($urandom_range(1, 0) == 1) branch = 1'b1;
      else jump = 1'b1;
      target = $urandom;
    end
  endtask

  task automatic wait_req();
    captured = 0;
    for (int i = 0; i < 20 && !captured; i++) drive_cycle(1'b1);
    check("req_wait_timeout", 32'(captured), 32'h1);
  endtask

  task automatic redirect_after_req(input int lat, input logic [31:0] tgt, input bit br);
    lat_min = lat;
    lat_max = lat;
    wait_req();
    force_redir = 1;
    force_tgt   = tgt;
    force_br    = br;
    drive_cycle(1'b1);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] req_pc = 32'h0;
  logic [31:0] e_pc = 32'h0, e_add4 = 32'h0, e_inst = NOP;
  logic        e_valid = 1'b0;
  bit          outstanding = 0, live = 0, req_due = 0, idle_wait = 1;
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    logic [63:0] d;
    bit          nxt_due;
    bit          redir;
    if (!rst) begin
      check("rst_req", 32'(req), 32'h0);
      check("rst_valid", 32'(valid_o), 32'h0);
      check("rst_inst", inst_o, NOP);
      check("rst_pc", pc_o, 32'h0);
      exp_pc      = RST_PC;
      e_pc        = 32'h0;
      e_add4      = 32'h0;
      e_inst      = NOP;
      e_valid     = 1'b0;
      outstanding = 0;
      live        = 0;
      req_due     = 0;
      idle_wait   = 1;
      exp_q.delete();
    end else begin
      check("ifid_pc", pc_o, e_pc);
      check("ifid_add4", add4_o, e_add4);
      check("ifid_inst", inst_o, e_inst);
      check("ifid_valid", 32'(valid_o), 32'(e_valid));
      if (idle_wait) begin
        // First cycle out of reset: nothing issued yet, any response is stale.
        check("idle_req", 32'(req), 32'h0);
        idle_wait = 0;
        req_due   = 1;
      end else begin
        nxt_due = 0;
        redir   = branch | jump;
        check("req_timing", 32'(req), 32'(req_due));
        if (req) begin
          check("req_addr", addr, exp_pc);
          req_pc      = exp_pc;
          outstanding = 1;
          live        = 1;
        end
        if (rvalid && outstanding) begin
          outstanding = 0;
          if (live && !redir) exp_q.push_back({req_pc, inst_of(req_pc)});
          else if (!live) nxt_due = 1;
        end
        if (redir) begin
          exp_pc  = target & 32'hFFFF_FFFC;
          e_pc    = 32'h0;
          e_add4  = 32'h0;
          e_inst  = NOP;
          e_valid = 1'b0;
          live    = 0;
          exp_q.delete();
          if (!outstanding) nxt_due = 1;
        end else if (exp_q.size() > 0 && ifpip) begin
          d       = exp_q.pop_front();
          e_pc    = d[63:32];
          e_add4  = d[63:32] + 32'd4;
          e_inst  = d[31:0];
          e_valid = 1'b1;
          if (pcwrite) exp_pc = exp_pc + 32'd4;
          nxt_due = 1;
        end
        req_due = nxt_due;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0; pcwrite = 1'b0; ifpip = 1'b0; branch = 1'b0; jump = 1'b0;
    target = 32'h0; rvalid = 1'b0; rdata = 32'h0;

    // Straight-line fetch at latency 1
    repeat (3) drive_cycle(1'b0);
    repeat (20) drive_cycle(1'b1);

    // IF/ID stalls with the returned word parked in the hold buffer
    p_ifpip = 30;
    lat_min = 1; lat_max = 3;
    repeat (40) drive_cycle(1'b1);
    p_ifpip = 100;

    // Branch while a latency-3 request is pending; target is misaligned on purpose
    redirect_after_req(3, 32'h0000_0103, 1'b1);
    repeat (10) drive_cycle(1'b1);

    // Jump in the same cycle as the response
    redirect_after_req(1, 32'h0000_0200, 1'b0);
    repeat (10) drive_cycle(1'b1);

    // PC wrap: fetch at 0xFFFF_FFFC, next fetch 0x0
    redirect_after_req(2, 32'hFFFF_FFFC, 1'b0);
    repeat (12) drive_cycle(1'b1);

    // Reset during WAIT; the late response lands after release
    lat_min = 4; lat_max = 4;
    wait_req();
    drive_cycle(1'b1);
    repeat (2) drive_cycle(1'b0);
    repeat (15) drive_cycle(1'b1);

    // Random mix of latencies, stalls and redirects
    lat_min = 1; lat_max = 4;
    p_pcw = 85; p_ifpip = 75; p_redir = 6; redir_en = 1;
    repeat (2500) drive_cycle(1'b1);

    redir_en = 0;
    repeat (10) drive_cycle(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
